// File: rtl/pim_matrix_loader.sv
// pim_matrix_loader: streams A then B into flat operand arrays,
// pulses start once, holds operands until result_ready.
package types;
  localparam int WIDTH = 8;
  localparam int MATRIX_SIZE = 4;
endpackage

module pim_matrix_loader
  import types::*;
#(
  parameter int WIDTH = types::WIDTH,
  parameter int MATRIX_SIZE = types::MATRIX_SIZE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  output logic in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic in_last,
  input  logic flush,
  output logic [MATRIX_SIZE*MATRIX_SIZE-1:0][WIDTH-1:0] matrix_A,
  output logic [MATRIX_SIZE*MATRIX_SIZE-1:0][WIDTH-1:0] matrix_B,
  output logic start,
  input  logic result_ready,
  output logic busy,
  output logic err
);

  localparam int NN = MATRIX_SIZE * MATRIX_SIZE;
  localparam int IW = $clog2(NN);

  typedef enum logic [1:0] {
    LOAD_A,
    LOAD_B,
    START,
    WAIT
  } state_t;

  state_t state;
  logic [IW-1:0] idx;
  logic loading;
  logic beat;
  logic last_idx;
  logic final_b;

  assign loading  = (state == LOAD_A) || (state == LOAD_B);
  assign in_ready = rst_n && loading && !flush;
  assign beat     = in_valid && in_ready;
  assign last_idx = (idx == IW'(NN - 1));
  assign final_b  = (state == LOAD_B) && last_idx;
  assign busy     = (state == START) || (state == WAIT);

  // Load FSM: element capture, framing check, start pulse and hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= LOAD_A;
      idx      <= '0;
      matrix_A <= '0;
      matrix_B <= '0;
      start    <= 1'b0;
      err      <= 1'b0;
    end else begin
      start <= 1'b0;
      err   <= 1'b0;
      case (state)
        LOAD_A, LOAD_B: begin
          if (flush) begin
            idx   <= '0;
            state <= LOAD_A;
          end else if (beat) begin
            if (in_last && !final_b) begin
              err   <= 1'b1;
              idx   <= '0;
              state <= LOAD_A;
            end else begin
              if (state == LOAD_A) matrix_A[idx] <= in_data;
              else matrix_B[idx] <= in_data;
              if (last_idx) begin
                idx <= '0;
                if (state == LOAD_A) begin
                  state <= LOAD_B;
                end else begin
                  state <= START;
                  start <= 1'b1;
                  err   <= !in_last;
                end
              end else begin
                idx <= idx + 1'b1;
              end
            end
          end
        end
        START: state <= WAIT;
        WAIT: if (result_ready) state <= LOAD_A;
        default: state <= LOAD_A;
      endcase
    end
  end

endmodule

// File: tb/tb_pim_matrix_loader.sv
// tb_pim_matrix_loader: directed streams with a start-triggered
// scoreboard monitor comparing the presented operand arrays.
module tb_pim_matrix_loader;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int NN = N * N;

  typedef logic [NN-1:0][W-1:0] mat_t;
  typedef struct {
    mat_t a;
    mat_t b;
    int   cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid;
  logic in_ready;
  logic [W-1:0] in_data;
  logic in_last;
  logic flush;
  mat_t matrix_A;
  mat_t matrix_B;
  logic start;
  logic result_ready;
  logic busy;
  logic err;

  exp_t sb[$];
  exp_t e;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int err_seen = 0;
  int err_exp = 0;
  bit prev_start = 1'b0;

  mat_t a1, b1, a2, b2, a3;

  pim_matrix_loader #(.WIDTH(W), .MATRIX_SIZE(N)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_last(in_last),
    .flush(flush),
    .matrix_A(matrix_A),
    .matrix_B(matrix_B),
    .start(start),
    .result_ready(result_ready),
    .busy(busy),
    .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [NN*W-1:0] act,
                     input logic [NN*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every start pulse pops one expected operand pair.
  always @(negedge clk) begin
    if (err) err_seen++;
    if (start) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL start_unexpected: got start=1 expected no start");
      end else begin
        e = sb.pop_front();
        chk("matrix_A", matrix_A, e.a);
        chk("matrix_B", matrix_B, e.b);
        chk("start_cycle", cyc, e.cyc);
        chk("busy_at_start", busy, 1);
      end
    end
    if (prev_start) chk("start_width", start, 0);
    prev_start = start;
  end

  task automatic beat(input logic [W-1:0] d, input logic last);
    bit acc;
    in_data  = d;
    in_last  = last;
    in_valid = 1'b1;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) return;
    end
    errors++;
    checks++;
    $display("FAIL beat_timeout: got no handshake expected in_ready");
  endtask

  task automatic send_stream(input mat_t a, input mat_t b, input int n,
                             input bit toggle, input int bad_last);
    for (int k = 0; k < n; k++) begin
      if (toggle && k > 0) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      beat(k < NN ? a[k] : b[k-NN], (k == 2*NN-1) || (k == bad_last));
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic full_pair(input mat_t a, input mat_t b, input bit toggle);
    exp_t x;
    send_stream(a, b, 2*NN, toggle, -1);
    x.a = a;
    x.b = b;
    x.cyc = cyc;
    sb.push_back(x);
  endtask

  task automatic release_hold();
    @(posedge clk);
    #1;
    result_ready = 1'b1;
    @(posedge clk);
    #1;
    result_ready = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("in_ready_after_result", in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    bit bsy;
    for (int k = 0; k < NN; k++) begin
      a1[k] = W'(k + 1);
      b1[k] = (k / N == k % N) ? 8'd1 : 8'd0;
      a2[k] = W'(8'hA0 + k);
      b2[k] = W'((k * 7 + 3) & 8'hFF);
      a3[k] = W'(8'hF0 - k);
    end
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    in_last = 1'b0;
    flush = 1'b0;
    result_ready = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_start", start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_matrix_A", matrix_A, 0);
    chk("rst_matrix_B", matrix_B, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // 1: back-to-back load, result_ready during START ignored
    full_pair(a1, b1, 1'b0);
    in_valid = 1'b1;
    result_ready = 1'b1;
    @(negedge clk);
    chk("t1_in_ready_start", in_ready, 0);
    @(posedge clk);
    #1;
    result_ready = 1'b0;
    @(negedge clk);
    chk("t1_busy_wait", busy, 1);
    chk("t1_in_ready_wait", in_ready, 0);
    chk("t1_A0", matrix_A[0], 1);
    chk("t1_A15", matrix_A[15], 16);
    chk("t1_B5", matrix_B[5], 1);
    chk("t1_B6", matrix_B[6], 0);

    // 3: long hold in WAIT with in_valid high
    acc = 1'b0;
    bsy = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      acc |= in_ready;
      bsy &= busy;
    end
    chk("t3_no_accept", acc, 0);
    chk("t3_busy_hold", bsy, 1);
    chk("t3_A_frozen", matrix_A, a1);
    chk("t3_B_frozen", matrix_B, b1);
    release_hold();
    @(posedge clk);
    #1;

    // 2: toggled in_valid
    full_pair(a1, b1, 1'b1);
    repeat (3) @(negedge clk);
    chk("t2_no_err", err_seen, err_exp);
    release_hold();
    @(posedge clk);
    #1;

    // 4: premature in_last on beat 5
    send_stream(a2, b2, 5, 1'b0, 4);
    err_exp++;
    @(negedge clk);
    chk("t4_err_pulse", err, 1);
    chk("t4_in_ready", in_ready, 1);
    chk("t4_not_busy", busy, 0);
    chk("t4_A3_written", matrix_A[3], 8'hA3);
    chk("t4_A4_kept", matrix_A[4], 8'd5);
    @(negedge clk);
    chk("t4_err_width", err, 0);
    @(posedge clk);
    #1;
    full_pair(a2, b2, 1'b0);
    release_hold();
    @(posedge clk);
    #1;

    // 5: flush on beat 20
    send_stream(a1, b2, 19, 1'b0, -1);
    in_valid = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    chk("t5_flush_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    full_pair(a3, b1, 1'b0);
    release_hold();
    @(posedge clk);
    #1;

    // 6: reset during LOAD_B beat 10
    send_stream(a1, b1, 25, 1'b0, -1);
    in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_A", matrix_A, 0);
    chk("t6_rst_B", matrix_B, 0);
    chk("t6_rst_start", start, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_err", err, 0);
    chk("t6_rst_in_ready", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_start_in_rst", start, 0);
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    full_pair(a2, b1, 1'b0);
    release_hold();

    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    chk("err_count", err_seen, err_exp);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
